// File: rtl/apb_completer_regs.sv
// rtl/apb_completer_regs.sv - APB4 completer serving NUM_REGS RW control registers plus one RO status word
module apb_completer_regs #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          DATA_WIDTH  = 32,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] SECURE_MASK = 16'h0000,
    parameter logic [15:0] PRIV_MASK   = 16'h0000
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic [ADDR_WIDTH-1:0]    PADDR,
    input  logic                     PWRITE,
    input  logic [31:0]              PWDATA,
    input  logic [3:0]               PSTRB,
    input  logic [2:0]               PPROT,
    output logic [31:0]              PRDATA,
    output logic                     PREADY,
    output logic                     PSLVERR,
    input  logic [31:0]              status_in,
    output logic [NUM_REGS*32-1:0]   reg_out
);

    localparam int         IW = ADDR_WIDTH - 2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          setup_q;
    logic [31:0]   regs [NUM_REGS];
    logic [IW-1:0] idx;
    logic [31:0]   rd_val;
    logic          sec_err, priv_err, err;
    logic          wr_en;
    wire           unused_prot = PPROT[2];

    assign idx = PADDR[ADDR_WIDTH-1:2];

    always_comb begin
        rd_val   = '0;
        sec_err  = 1'b0;
        priv_err = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IW'(i)) begin
                rd_val   = regs[i];
                sec_err  = SECURE_MASK[i] & PPROT[1];
                priv_err = PWRITE & PRIV_MASK[i] & ~PPROT[0];
            end
        end
        if (idx == IW'(NUM_REGS)) begin
            rd_val = status_in;
        end
        err = (PADDR[1:0] != 2'b00) | (idx > IW'(NUM_REGS)) |
              ((idx == IW'(NUM_REGS)) & PWRITE) | sec_err | priv_err;
    end

    // A transfer may only start once a SETUP cycle (PSEL without PENABLE) has been seen,
    // so a PENABLE still high right after DONE is ignored.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= IDLE;
            cnt     <= '0;
            setup_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            setup_q <= PSEL & ~PENABLE;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (PSEL && PENABLE && setup_q) begin
                    cnt_nxt   = WS;
                    state_nxt = (WS == 4'd0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (cnt <= 4'd1) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign PREADY  = (state == DONE);
    assign PSLVERR = PREADY & err;
    assign PRDATA  = (PREADY && !PWRITE && !err) ? rd_val : 32'h0;
    assign wr_en   = PREADY & PWRITE & ~err;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == IW'(i)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (PSTRB[b]) begin
                            regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = regs[i];
        end
    end

endmodule

// File: tb/tb_apb_completer_regs.sv
// tb/tb_apb_completer_regs.sv - self-checking bench for apb_completer_regs across three wait/protection configurations
module tb_apb_completer_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel_v [3];
    logic        penable;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] status;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    logic [255:0] rout   [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          ws_p   [3] = '{0, 3, 5};
    logic [7:0]  sec_p  [3] = '{8'h02, 8'h00, 8'h00};
    logic [7:0]  priv_p [3] = '{8'h01, 8'h00, 8'h00};

    logic [31:0] mreg [3][8];
    bit          active [3];
    int          due    [3];
    logic [11:0] t_addr  [3];
    logic        t_write [3];
    logic [31:0] t_wdata [3];
    logic [3:0]  t_strb  [3];
    logic [2:0]  t_prot  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_completer_regs #(.WAIT_STATES(0), .SECURE_MASK(16'h0002), .PRIV_MASK(16'h0001)) dut0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel_v[0]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]),
        .status_in(status), .reg_out(rout[0]));

    apb_completer_regs #(.WAIT_STATES(3)) dut1 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel_v[1]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]),
        .status_in(status), .reg_out(rout[1]));

    apb_completer_regs #(.WAIT_STATES(5)) dut2 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel_v[2]), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]),
        .status_in(status), .reg_out(rout[2]));

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level outcome of one access against the model register file
    task automatic model_access(input int k, output bit err, output logic [31:0] rd);
        int idx;
        idx = int'(t_addr[k] >> 2);
        err = (t_addr[k][1:0] != 2'b00) || (idx > 8) || (t_write[k] && idx == 8) ||
              (idx < 8 && sec_p[k][idx % 8] && t_prot[k][1]) ||
              (idx < 8 && t_write[k] && priv_p[k][idx % 8] && !t_prot[k][0]);
        rd = 32'h0;
        if (!err && !t_write[k]) rd = (idx == 8) ? status : mreg[k][idx % 8];
        if (!err && t_write[k])
            for (int b = 0; b < 4; b++)
                if (t_strb[k][b]) mreg[k][idx % 8][8*b +: 8] = t_wdata[k][8*b +: 8];
    endtask

    logic [255:0] exp_vec;
    bit           m_err;
    logic [31:0]  m_rd;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) exp_vec[32*i +: 32] = mreg[k][i];
            check(rout[k] == exp_vec, "reg_out", rout[k], exp_vec);
            if (active[k] && cyc == due[k]) begin
                model_access(k, m_err, m_rd);
                check(pready[k] == 1'b1, "pready_done", 256'(pready[k]), 256'd1);
                check(pslverr[k] == m_err, "pslverr", 256'(pslverr[k]), 256'(m_err));
                check(prdata[k] == m_rd, "prdata", 256'(prdata[k]), 256'(m_rd));
                active[k] = 1'b0;
            end else begin
                check(pready[k] == 1'b0, "pready_idle", 256'(pready[k]), 256'd0);
                check(prdata[k] == 32'h0, "prdata_idle", 256'(prdata[k]), 256'd0);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that ends DONE
    task automatic xfer(input int k, input logic [11:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, input bit hold,
                        output logic [31:0] rd, output logic er);
        psel_v[k] = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = d; pstrb = s; pprot = p;
        @(posedge clk); #1;
        penable = 1'b1;
        t_addr[k] = a; t_write[k] = w; t_wdata[k] = d; t_strb[k] = s; t_prot[k] = p;
        due[k] = cyc + ws_p[k] + 1;
        active[k] = 1'b1;
        while (cyc < due[k]) begin @(posedge clk); #1; end
        @(negedge clk);
        rd = prdata[k]; er = pslverr[k];
        @(posedge clk); #1;
        if (hold) begin @(posedge clk); #1; end
        psel_v[k] = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            psel_v[k] = 1'b0; active[k] = 1'b0; due[k] = 0;
            for (int i = 0; i < 8; i++) mreg[k][i] = 32'h0;
        end
        penable = 1'b0; paddr = '0; pwrite = 1'b0; pwdata = '0; pstrb = '0; pprot = '0;
        status = 32'h0;
        @(negedge clk);
        check(pready[0] == 1'b0, "rst_pready", 256'(pready[0]), 256'd0);
        check(pslverr[0] == 1'b0, "rst_pslverr", 256'(pslverr[0]), 256'd0);
        check(rout[0] == 256'd0, "rst_reg_out", rout[0], 256'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        xfer(0, 12'h004, 1, 32'hDEADBEEF, 4'hF, 3'b000, 0, rd, er);
        check(er == 1'b0, "wr_ok", 256'(er), 256'd0);
        xfer(0, 12'h004, 0, 32'h0, 4'h0, 3'b000, 0, rd, er);
        check(rd == 32'hDEADBEEF, "rd_deadbeef", 256'(rd), 256'hDEADBEEF);
        xfer(0, 12'h000, 1, 32'h11223344, 4'hF, 3'b001, 0, rd, er);
        xfer(0, 12'h000, 1, 32'hAABBCCDD, 4'b0101, 3'b001, 0, rd, er);
        check(rout[0][31:0] == 32'h11BB33DD, "strobe_merge", 256'(rout[0][31:0]), 256'h11BB33DD);
        status = 32'h5A5A0001;
        xfer(0, 12'h020, 0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check(rd == 32'h5A5A0001, "status_rd", 256'(rd), 256'h5A5A0001);
        xfer(0, 12'h002, 1, 32'hFFFFFFFF, 4'hF, 3'b001, 0, rd, er);
        check(er == 1'b1, "misaligned_err", 256'(er), 256'd1);
        xfer(0, 12'h020, 1, 32'hFFFFFFFF, 4'hF, 3'b001, 0, rd, er);
        check(er == 1'b1, "status_wr_err", 256'(er), 256'd1);
        xfer(0, 12'h040, 0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check(er == 1'b1 && rd == 32'h0, "oor_rd_err", 256'({er, rd}), 256'({1'b1, 32'h0}));
        xfer(0, 12'h004, 0, 32'h0, 4'h0, 3'b010, 0, rd, er);
        check(er == 1'b1 && rd == 32'h0, "secure_rd_err", 256'({er, rd}), 256'({1'b1, 32'h0}));
        xfer(0, 12'h000, 1, 32'h0, 4'hF, 3'b000, 0, rd, er);
        check(er == 1'b1, "priv_wr_err", 256'(er), 256'd1);
        check(rout[0][31:0] == 32'h11BB33DD, "priv_unchanged", 256'(rout[0][31:0]), 256'h11BB33DD);
        xfer(0, 12'h000, 1, 32'h000000FF, 4'hF, 3'b001, 0, rd, er);
        check(er == 1'b0, "priv_wr_ok", 256'(er), 256'd0);
        @(negedge clk);
        check(rout[0][31:0] == 32'h000000FF, "priv_wr_val", 256'(rout[0][31:0]), 256'hFF);
        @(posedge clk); #1;
        xfer(0, 12'h008, 1, 32'h12345678, 4'h0, 3'b001, 0, rd, er);
        check(er == 1'b0, "strb0_noerr", 256'(er), 256'd0);
        xfer(0, 12'h004, 0, 32'h0, 4'h0, 3'b000, 1, rd, er);
        repeat (3) @(posedge clk);
        #1;

        xfer(1, 12'h008, 1, 32'h0BADC0DE, 4'hF, 3'b001, 0, rd, er);
        xfer(1, 12'h008, 0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check(rd == 32'h0BADC0DE, "ws3_rd", 256'(rd), 256'h0BADC0DE);
        psel_v[1] = 1'b1; penable = 1'b0; paddr = 12'h00C; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 psel_v[1] = 1'b0; penable = 1'b0;
        repeat (6) @(posedge clk);
        #1 check(rout[1][127:96] == 32'h0, "abort_no_write", 256'(rout[1][127:96]), 256'd0);

        psel_v[2] = 1'b1; penable = 1'b0; paddr = 12'h000; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF; pprot = 3'b001;
        @(posedge clk); #1 penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        psel_v[2] = 1'b0; penable = 1'b0;
        for (int k = 0; k < 3; k++) for (int i = 0; i < 8; i++) mreg[k][i] = 32'h0;
        @(negedge clk);
        check(rout[2] == 256'd0 && pready[2] == 1'b0, "midrst_clear", 256'(rout[2]), 256'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        xfer(2, 12'h000, 1, 32'h12345678, 4'hF, 3'b001, 0, rd, er);
        xfer(2, 12'h000, 0, 32'h0, 4'h0, 3'b001, 0, rd, er);
        check(rd == 32'h12345678 && er == 1'b0, "post_rst_rd", 256'(rd), 256'h12345678);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
